fl_checkpoint_ctrl: RTL and testbench

Branch-checkpoint controller for the integer physical-register free list in the rename stage. It mirrors the free list's busy vector from granted allocations and commit-time frees. It snapshots that vector into a ring of checkpoints when rename requests one, and retires or squashes checkpoints as branches resolve. On a mispredict it drives `recover`/`recover_fl` so the free list reloads the snapshot on the same clock edge.

---
 rtl/fl_checkpoint_ctrl.sv | 152 +++++++++++++++
 tb/tb_fl_checkpoint_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fl_checkpoint_ctrl.sv
// fl_checkpoint_ctrl
//   Branch-checkpoint controller for the integer physical-register free list.
//   It keeps a mirror of the free list's busy vector (1 = busy, bit 0 always
//   busy). On request it snapshots that mirror into a ring of checkpoint
//   slots. Branch resolution either retires a slot (correct) or rolls back to
//   it (mispredict). A rollback drives recover/recover_fl so the free list
//   reloads on the same edge.
//
// Ports
//   clock, reset        : single clock, asynchronous active-high reset
//   alloc_valid/idx     : PRFs granted by the free list this cycle, one per lane
//   free_valid/idx      : PRFs released at commit this cycle, one per lane
//   ckpt_req            : rename group contains a branch
//   ckpt_ready/ckpt_tag : slot available / tag granted (tail slot)
//   resolve_valid/tag/mispredict : branch resolution
//   recover, recover_fl : restore strobe and restored busy vector
//   ckpt_count          : live span between head and tail
module fl_checkpoint_ctrl #(
  parameter  int PRF_SIZE     = 64,
  parameter  int RENAME_WIDTH = 4,
  parameter  int CKPT_NUM     = 4,
  localparam int IDX_W        = $clog2(PRF_SIZE),
  localparam int TAG_W        = $clog2(CKPT_NUM)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [RENAME_WIDTH-1:0]       alloc_valid,
  input  logic [RENAME_WIDTH*IDX_W-1:0] alloc_idx,
  input  logic [RENAME_WIDTH-1:0]       free_valid,
  input  logic [RENAME_WIDTH*IDX_W-1:0] free_idx,
  input  logic                          ckpt_req,
  output logic                          ckpt_ready,
  output logic [TAG_W-1:0]              ckpt_tag,
  input  logic                          resolve_valid,
  input  logic [TAG_W-1:0]              resolve_tag,
  input  logic                          resolve_mispredict,
  output logic                          recover,
  output logic [PRF_SIZE-1:0]           recover_fl,
  output logic [TAG_W:0]                ckpt_count
);

  localparam logic [PRF_SIZE-1:0] X0_BUSY = {{(PRF_SIZE-1){1'b0}}, 1'b1};

  logic [PRF_SIZE-1:0] mirror;
  logic [PRF_SIZE-1:0] snap [CKPT_NUM];
  logic [CKPT_NUM-1:0] live;
  logic [TAG_W:0]      head;
  logic [TAG_W:0]      tail;

  logic [PRF_SIZE-1:0] free_mask;
  logic [PRF_SIZE-1:0] alloc_mask;
  logic [PRF_SIZE-1:0] mirror_nx;
  logic [TAG_W-1:0]    head_low;
  logic [TAG_W-1:0]    tail_low;
  logic                full;
  logic [TAG_W:0]      occupancy;
  logic                mispredict_hit;
  logic                correct_hit;
  logic                grant;
  logic                reclaim;
  logic [TAG_W-1:0]    tag_off;
  logic [TAG_W-1:0]    slot_off;
  logic [TAG_W:0]      rollback_tail;
  logic [CKPT_NUM-1:0] kill;
  logic [CKPT_NUM-1:0] live_nx;

  // Lane masks; duplicate indices simply set the same bit twice.
  always_comb begin
    free_mask  = '0;
    alloc_mask = '0;
    for (int l = 0; l < RENAME_WIDTH; l++) begin
      if (free_valid[l])  free_mask[free_idx[l*IDX_W +: IDX_W]]   = 1'b1;
      if (alloc_valid[l]) alloc_mask[alloc_idx[l*IDX_W +: IDX_W]] = 1'b1;
    end
  end

  // Frees first, then allocations; x0 can never become free.
  assign mirror_nx = (mirror & ~free_mask) | alloc_mask | X0_BUSY;

  assign head_low  = head[TAG_W-1:0];
  assign tail_low  = tail[TAG_W-1:0];
  assign full      = (head_low == tail_low) && (head[TAG_W] != tail[TAG_W]);
  assign occupancy = tail - head;

  assign mispredict_hit = resolve_valid &  resolve_mispredict & live[resolve_tag];
  assign correct_hit    = resolve_valid & ~resolve_mispredict & live[resolve_tag];

  assign ckpt_ready = !full && !mispredict_hit;
  assign ckpt_tag   = tail_low;
  assign ckpt_count = occupancy;
  assign grant      = ckpt_req && ckpt_ready;

  // Reclaim looks at the registered live bits, so a head slot resolved this
  // cycle is popped on the following edge.
  assign reclaim = (head != tail) && !live[head_low];

  assign recover    = mispredict_hit;
  assign recover_fl = mispredict_hit ? ((snap[resolve_tag] & ~free_mask) | X0_BUSY)
                                     : mirror;

  // A live tag always lies in [head, tail), so its distance from head
  // rebuilds the full pointer including the wrap bit.
  assign tag_off       = resolve_tag - head_low;
  assign rollback_tail = head + {1'b0, tag_off};

  // Slots at or beyond the mispredicted tag (in ring order from head) are
  // the wrong-path checkpoints.
  always_comb begin
    kill     = '0;
    slot_off = '0;
    for (int i = 0; i < CKPT_NUM; i++) begin
      slot_off = TAG_W'(i) - head_low;
      kill[i]  = mispredict_hit && (slot_off >= tag_off) &&
                 ({1'b0, slot_off} < occupancy);
    end
  end

  always_comb begin
    live_nx = live;
    if (correct_hit) live_nx[resolve_tag] = 1'b0;
    live_nx = live_nx & ~kill;
    if (grant) live_nx[tail_low] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mirror <= X0_BUSY;
      live   <= '0;
      head   <= '0;
      tail   <= '0;
    end else begin
      mirror <= mispredict_hit ? recover_fl : mirror_nx;
      live   <= live_nx;
      if (reclaim) head <= head + 1'b1;
      if (mispredict_hit) tail <= rollback_tail;
      else if (grant)     tail <= tail + 1'b1;
    end
  end

  // Committed frees are applied to every snapshot so they survive a restore.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CKPT_NUM; i++) snap[i] <= X0_BUSY;
    end else begin
      for (int i = 0; i < CKPT_NUM; i++) begin
        if (grant && (tail_low == TAG_W'(i))) snap[i] <= mirror_nx;
        else                                  snap[i] <= snap[i] & ~free_mask;
      end
    end
  end

endmodule

// File: tb/tb_fl_checkpoint_ctrl.sv
module tb_fl_checkpoint_ctrl;

  localparam int PRF_SIZE = 64;
  localparam int RW       = 4;
  localparam int CKPT_NUM = 4;
  localparam int IDX_W    = 6;
  localparam int TAG_W    = 2;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [RW-1:0]          alloc_valid;
  logic [RW*IDX_W-1:0]    alloc_idx;
  logic [RW-1:0]          free_valid;
  logic [RW*IDX_W-1:0]    free_idx;
  logic                   ckpt_req;
  logic                   ckpt_ready;
  logic [TAG_W-1:0]       ckpt_tag;
  logic                   resolve_valid;
  logic [TAG_W-1:0]       resolve_tag;
  logic                   resolve_mispredict;
  logic                   recover;
  logic [PRF_SIZE-1:0]    recover_fl;
  logic [TAG_W:0]         ckpt_count;

  int errors = 0;
  int checks = 0;

  fl_checkpoint_ctrl #(
    .PRF_SIZE(PRF_SIZE), .RENAME_WIDTH(RW), .CKPT_NUM(CKPT_NUM)
  ) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
    .free_valid(free_valid), .free_idx(free_idx),
    .ckpt_req(ckpt_req), .ckpt_ready(ckpt_ready), .ckpt_tag(ckpt_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_mispredict(resolve_mispredict),
    .recover(recover), .recover_fl(recover_fl), .ckpt_count(ckpt_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr;
    alloc_valid = '0; alloc_idx = '0;
    free_valid  = '0; free_idx  = '0;
    ckpt_req = 1'b0;
    resolve_valid = 1'b0; resolve_tag = '0; resolve_mispredict = 1'b0;
  endtask

  task automatic step;
    @(posedge clock);
    #1;
    clr();
  endtask

  task automatic do_reset;
    clr();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic alloc(input int lane, input int idx);
    alloc_valid[lane] = 1'b1;
    alloc_idx[lane*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  task automatic free(input int lane, input int idx);
    free_valid[lane] = 1'b1;
    free_idx[lane*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  task automatic resolve(input int tag, input logic mis);
    resolve_valid = 1'b1;
    resolve_tag = TAG_W'(tag);
    resolve_mispredict = mis;
  endtask

  initial begin
    // Reset and idle
    do_reset();
    chk("rst_ready", 64'(ckpt_ready), 64'd1);
    chk("rst_count", 64'(ckpt_count), 64'd0);
    chk("rst_tag", 64'(ckpt_tag), 64'd0);
    chk("rst_recover", 64'(recover), 64'd0);
    chk("rst_fl", recover_fl, 64'h1);
    alloc(0, 5); alloc(1, 6);
    step();
    chk("alloc56_mirror", recover_fl, 64'h61);

    // Checkpoint with p5, p7 afterwards, mispredict restores p5 only
    do_reset();
    alloc(0, 5); ckpt_req = 1'b1;
    #1;
    chk("t3_ready", 64'(ckpt_ready), 64'd1);
    chk("t3_tag0", 64'(ckpt_tag), 64'd0);
    step();
    chk("t3_count1", 64'(ckpt_count), 64'd1);
    alloc(0, 7);
    step();
    chk("t3_mirror_a1", recover_fl, 64'ha1);
    resolve(0, 1'b1);
    #1;
    chk("t3_recover", 64'(recover), 64'd1);
    chk("t3_recover_fl", recover_fl, 64'h21);
    chk("t3_ready_mis", 64'(ckpt_ready), 64'd0);
    step();
    chk("t3_count0", 64'(ckpt_count), 64'd0);
    chk("t3_mirror_after", recover_fl, 64'h21);
    chk("t3_tag_back", 64'(ckpt_tag), 64'd0);
    chk("t3_recover_low", 64'(recover), 64'd0);

    // Frees after the snapshot (and in the restore cycle) survive the restore
    do_reset();
    alloc(2, 9); alloc(3, 10);
    step();
    ckpt_req = 1'b1;
    step();
    step();
    free(1, 9);
    step();
    chk("t4_mirror_p10", recover_fl, 64'h401);
    resolve(0, 1'b1); free(0, 10);
    #1;
    chk("t4_recover", 64'(recover), 64'd1);
    chk("t4_bit9", 64'(recover_fl[9]), 64'd0);
    chk("t4_recover_fl", recover_fl, 64'h1);
    step();
    chk("t4_mirror_after", recover_fl, 64'h1);

    // Fill the ring, out-of-order retire, reclaim, then wrap-around rollback
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ckpt_req = 1'b1;
      #1;
      chk("t5_fill_tag", 64'(ckpt_tag), 64'(i));
      step();
    end
    chk("t5_full_ready", 64'(ckpt_ready), 64'd0);
    chk("t5_full_count", 64'(ckpt_count), 64'd4);
    ckpt_req = 1'b1;
    step();
    chk("t5_no_grant_full", 64'(ckpt_count), 64'd4);
    resolve(2, 1'b0);
    step();
    chk("t5_res2_ready", 64'(ckpt_ready), 64'd0);
    chk("t5_res2_count", 64'(ckpt_count), 64'd4);
    resolve(0, 1'b0);
    step();
    chk("t5_res0_ready_same", 64'(ckpt_ready), 64'd0);
    step();
    chk("t5_reclaim_ready", 64'(ckpt_ready), 64'd1);
    chk("t5_reclaim_count", 64'(ckpt_count), 64'd3);
    chk("t5_reclaim_tag", 64'(ckpt_tag), 64'd0);
    ckpt_req = 1'b1;
    step();
    chk("t5_wrap_full", 64'(ckpt_count), 64'd4);
    resolve(3, 1'b1);
    #1;
    chk("t5_wrap_recover", 64'(recover), 64'd1);
    step();
    chk("t5_wrap_count", 64'(ckpt_count), 64'd2);
    chk("t5_wrap_tag", 64'(ckpt_tag), 64'd3);
    chk("t5_wrap_ready", 64'(ckpt_ready), 64'd1);
    resolve(0, 1'b1);
    #1;
    chk("t5_killed_ignored", 64'(recover), 64'd0);
    step();

    // Mispredict squashes younger slots only
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ckpt_req = 1'b1;
      step();
    end
    chk("t6_count3", 64'(ckpt_count), 64'd3);
    resolve(1, 1'b1);
    #1;
    chk("t6_recover", 64'(recover), 64'd1);
    step();
    chk("t6_count1", 64'(ckpt_count), 64'd1);
    chk("t6_tag1", 64'(ckpt_tag), 64'd1);
    resolve(2, 1'b1);
    #1;
    chk("t6_tag2_ignored", 64'(recover), 64'd0);
    step();
    chk("t6_count_still1", 64'(ckpt_count), 64'd1);
    resolve(0, 1'b1);
    #1;
    chk("t6_tag0_live", 64'(recover), 64'd1);
    step();
    chk("t6_count0", 64'(ckpt_count), 64'd0);

    // Mispredict, request and wrong-path alloc in the same cycle
    do_reset();
    ckpt_req = 1'b1;
    step();
    ckpt_req = 1'b1; resolve(0, 1'b1); alloc(0, 12);
    #1;
    chk("t7_ready", 64'(ckpt_ready), 64'd0);
    chk("t7_recover", 64'(recover), 64'd1);
    chk("t7_recover_fl", recover_fl, 64'h1);
    step();
    chk("t7_no_p12", recover_fl, 64'h1);
    chk("t7_no_grant", 64'(ckpt_count), 64'd0);

    // Asynchronous reset mid-fill
    ckpt_req = 1'b1; alloc(0, 20);
    step();
    ckpt_req = 1'b1;
    step();
    chk("t8_pre_count", 64'(ckpt_count), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("t8_async_count", 64'(ckpt_count), 64'd0);
    chk("t8_async_fl", recover_fl, 64'h1);
    chk("t8_async_ready", 64'(ckpt_ready), 64'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
